mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Controller that sequences the 8-bit shift-add multiplier datapath to compute one full product per request. It accepts operands through a start/result handshake and issues the command stream CLEAR, LOADA, LOADB, then STEP ×WIDTH over the datapath's s/op/in/done interface. It captures the 16-bit product and runs a watchdog on the datapath's done line. It sits between the requesting logic and the multiplier datapath.

## Interface
- WIDTH, 8: operand width; number of STEP commands issued.
- TIMEOUT, 15: maximum cycles spent in WAIT before the error trap.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- start  in  1  request; sampled only in IDLE or ERR.
- a  in  WIDTH  multiplicand; latched when start is accepted.
- b  in  WIDTH  multiplier; latched when start is accepted.
- busy  out  1  high from start acceptance through the DONE cycle.
- result  out  2*WIDTH  product; updated on completion, held until the next completion.
- result_valid  out  1  one-cycle pulse in the DONE state.
- err  out  1  high in ERR (watchdog expired).
- dp_s  out  1  datapath command strobe; high only in ISSUE.
- dp_op  out  2  command code: 00 CLEAR, 01 LOADA, 10 LOADB, 11 STEP.
- dp_in  out  WIDTH  operand to datapath: a_reg for LOADA, b_reg for LOADB, 0 otherwise.
- dp_done  in  1  datapath idle/ready indication.
- dp_out  in  2*WIDTH  datapath accumulator.

## Operation
- Reset values:
  - Outputs: busy=0, result=0, result_valid=0, err=0, dp_s=0, dp_op=00, dp_in=0.
  - Internal: state=IDLE, cmd_idx=0, wait_cnt=0.
- Command list, indexed by cmd_idx:
  - 0: CLEAR.
  - 1: LOADA.
  - 2: LOADB.
  - 3 to WIDTH+2: STEP.
- States:
  - IDLE: on start, latch a/b into a_reg/b_reg, set cmd_idx=0, go to ISSUE.
  - ISSUE: dp_s=1, dp_op/dp_in per cmd_idx; go to SETTLE.
  - SETTLE: dp_s=0; dp_done ignored; clear wait_cnt; go to WAIT.
  - WAIT: dp_s=0.
    - If dp_done=1 and cmd_idx<WIDTH+2: increment cmd_idx, go to ISSUE.
    - If dp_done=1 and cmd_idx=WIDTH+2: result<=dp_out, go to DONE.
    - If dp_done=0: increment wait_cnt. When wait_cnt reaches TIMEOUT-1 with dp_done still 0, go to ERR.
  - DONE: result_valid=1, busy=1; go to IDLE.
  - ERR: err=1, busy=0; result unchanged. On start, clear err, latch operands, go to ISSUE with cmd_idx=0. Otherwise stay.
- busy=1 in ISSUE, SETTLE, WAIT, DONE.
- start while busy is ignored; operands are not re-latched.
- a/b changes after acceptance have no effect.
- dp_op and dp_in are held stable in SETTLE/WAIT (same as ISSUE) and return to 00/0 in IDLE, DONE and ERR.
- Widths: cmd_idx holds 0..WIDTH+2; wait_cnt holds 0..TIMEOUT-1 with no wrap. result is copied unmodified from dp_out.

## Timing
- A command costs ISSUE(1) + SETTLE(1) + WAIT(≥1) cycles. Minimum is 3 cycles when dp_done is high in the first WAIT cycle.
- Minimum latency is 34 cycles from the start-accepting edge to the result_valid cycle: 11 commands × 3, plus DONE.
- result is valid from the DONE cycle onward; result_valid is exactly 1 cycle.
- The back-to-back request earliest start is the cycle after DONE (IDLE).
- Watchdog: ERR is entered TIMEOUT cycles after entering WAIT with dp_done continuously low. The counter restarts in each SETTLE.
- Reset mid-operation: all state is cleared asynchronously. No partial result is written, and the next command begins only after a new start.
- Simultaneous start and reset: reset wins.

## Test plan
- a=3, b=5, datapath responds in 1 cycle → dp_op sequence 00,01,10,11×8; result=15, result_valid pulse at cycle 34, busy low after.
- a=255, b=255 → result=65025. Then a=0, b=77 back-to-back from IDLE → result=0. result holds 65025 until the second DONE.
- Datapath with 2-cycle done delay on every command → each command takes 4 cycles; result correct; dp_s high exactly 11 cycles total.
- dp_done stuck low after LOADA issue → err=1 exactly TIMEOUT cycles after WAIT entry, busy=0, result unchanged. Then start with a=2, b=4 and a healthy datapath → err clears, result=8.
- start pulsed with a=9, b=9 during STEP commands of a 6×7 operation → ignored; result=42.
- reset asserted mid-LOADB → all outputs zero immediately, no result_valid. A new start with a=7, b=6 → result=42.

Source files
------------

// File: rtl/mult_sequencer.sv
// Command sequencer for the shift-add multiplier datapath.
// It walks CLEAR/LOADA/LOADB/STEPxWIDTH, captures the product and runs a watchdog on dp_done.
module mult_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 err,
    output logic                 dp_s,
    output logic [1:0]           dp_op,
    output logic [WIDTH-1:0]     dp_in,
    input  logic                 dp_done,
    input  logic [2*WIDTH-1:0]   dp_out
);

    localparam int LAST_CMD = WIDTH + 2;
    localparam int IDX_W    = $clog2(WIDTH + 3);
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOADA = 2'b01;
    localparam logic [1:0] OP_LOADB = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_cmd_idx;
    logic [IDX_W-1:0]     w_cmd_idx_nxt;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [CNT_W-1:0]     w_wait_cnt_nxt;
    logic [2*WIDTH-1:0]   r_result;
    logic [2*WIDTH-1:0]   w_result_nxt;
    logic [WIDTH-1:0]     r_a_reg;
    logic [WIDTH-1:0]     r_b_reg;
    logic                 w_latch;
    logic [1:0]           w_op;
    logic [WIDTH-1:0]     w_operand;

    function automatic logic [1:0] cmd_op(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(0))
            return OP_CLEAR;
        else if (idx == IDX_W'(1))
            return OP_LOADA;
        else if (idx == IDX_W'(2))
            return OP_LOADB;
        else
            return OP_STEP;
    endfunction

    assign w_op = cmd_op(r_cmd_idx);

    always_comb begin
        w_operand = '0;
        case (w_op)
            OP_LOADA: w_operand = r_a_reg;
            OP_LOADB: w_operand = r_b_reg;
            default:  w_operand = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cmd_idx  <= '0;
            r_wait_cnt <= '0;
            r_result   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_idx  <= w_cmd_idx_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_result   <= w_result_nxt;
        end
    end

    // Operands are only consumed after a latch, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_a_reg <= a;
            r_b_reg <= b;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_idx_nxt  = r_cmd_idx;
        w_wait_cnt_nxt = r_wait_cnt;
        w_result_nxt   = r_result;
        w_latch        = 1'b0;
        busy           = 1'b0;
        result_valid   = 1'b0;
        err            = 1'b0;
        dp_s           = 1'b0;
        dp_op          = OP_CLEAR;
        dp_in          = '0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch       = 1'b1;
                    w_cmd_idx_nxt = '0;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy        = 1'b1;
                dp_s        = 1'b1;
                dp_op       = w_op;
                dp_in       = w_operand;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy           = 1'b1;
                dp_op          = w_op;
                dp_in          = w_operand;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                busy  = 1'b1;
                dp_op = w_op;
                dp_in = w_operand;
                if (dp_done) begin
                    if (r_cmd_idx == IDX_W'(LAST_CMD)) begin
                        w_result_nxt = dp_out;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_cmd_idx_nxt = r_cmd_idx + IDX_W'(1);
                        w_state_nxt   = S_ISSUE;
                    end
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    w_latch       = 1'b1;
                    w_cmd_idx_nxt = '0;
                    w_state_nxt   = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign result = r_result;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shift-add datapath and a result scoreboard.
module tb_mult_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic [15:0]       result;
    logic              result_valid;
    logic              err;
    logic              dp_s;
    logic [1:0]        dp_op;
    logic [WIDTH-1:0]  dp_in;
    logic              dp_done;
    logic [15:0]       dp_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    mult_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .result(result), .result_valid(result_valid), .err(err),
        .dp_s(dp_s), .dp_op(dp_op), .dp_in(dp_in), .dp_done(dp_done), .dp_out(dp_out)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: done drops for dly cycles after each strobe.
    logic [1:0]  dly = 2'd1;
    logic        arm_stuck = 1'b0;
    logic [7:0]  m_ra, m_rb;
    logic [15:0] m_acc;
    logic [3:0]  m_step;
    logic [1:0]  m_busy;
    logic        m_stuck;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ra <= '0; m_rb <= '0; m_acc <= '0; m_step <= '0; m_busy <= '0; m_stuck <= 1'b0;
        end else begin
            if (!arm_stuck) m_stuck <= 1'b0;
            if (dp_s) begin
                m_busy <= dly;
                case (dp_op)
                    2'b00: begin m_acc <= '0; m_step <= '0; end
                    2'b01: begin m_ra <= dp_in; if (arm_stuck) m_stuck <= 1'b1; end
                    2'b10: m_rb <= dp_in;
                    default: begin
                        if (m_step < 4'd8) begin
                            if (m_rb[m_step[2:0]]) m_acc <= m_acc + (16'(m_ra) << m_step);
                        end else begin
                            m_acc <= m_acc ^ 16'hA5A5;
                        end
                        m_step <= m_step + 4'd1;
                    end
                endcase
            end else if (m_busy != 2'd0) begin
                m_busy <= m_busy - 2'd1;
            end
        end
    end

    assign dp_done = !m_stuck && (m_busy == 2'd0);
    assign dp_out  = m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives start there so it is sampled on the next edge.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input int inj,
                          input int exp_lat, input int exp_strobes);
        int          n;
        int          strobes;
        logic        seen;
        logic        held_ok;
        logic [15:0] held;
        logic [15:0] expv;
        logic [21:0] ops;
        logic [21:0] ops_exp;
        logic [7:0]  la, lb;
        ops_exp = {2'b00, 2'b01, 2'b10, {8{2'b11}}};
        a = ta; b = tbv; start = 1'b1;
        exp_q.push_back(16'(ta) * 16'(tbv));
        held = result; held_ok = 1'b1; ops = '0; strobes = 0; seen = 1'b0; n = 0;
        la = '0; lb = '0; expv = '0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin start = 1'b0; a = ~ta; b = ~tbv; end
            if (inj > 0 && n == inj) begin start = 1'b1; a = 8'd9; b = 8'd9; end
            if (inj > 0 && n == inj + 1) start = 1'b0;
            if (dp_s) begin
                strobes++;
                ops = {ops[19:0], dp_op};
                if (dp_op == 2'b01) la = dp_in;
                if (dp_op == 2'b10) lb = dp_in;
            end
            if (result_valid) seen = 1'b1;
            else if (result !== held) held_ok = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        if (seen) begin
            chk("result", 32'(result), 32'(expv));
            chk("latency", n, exp_lat);
            chk("op_sequence", 32'(ops), 32'(ops_exp));
            chk("strobe_count", strobes, exp_strobes);
            chk("loada_operand", 32'(la), 32'(ta));
            chk("loadb_operand", 32'(lb), 32'(tbv));
            chk("result_held", 32'(held_ok), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("valid_pulse_end", 32'(result_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("result_kept", 32'(result), 32'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        found;
        logic        rv_seen;
        logic [15:0] held;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dp_s", 32'(dp_s), 32'd0);
        chk("rst_dp_op", 32'(dp_op), 32'd0);
        chk("rst_dp_in", 32'(dp_in), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'd3, 8'd5, 0, 34, 11);
        run_op(8'd255, 8'd255, 0, 34, 11);
        run_op(8'd0, 8'd77, 0, 34, 11);

        dly = 2'd2;
        run_op(8'd12, 8'd13, 0, 45, 11);
        dly = 2'd1;

        // Watchdog: datapath never finishes LOADA.
        arm_stuck = 1'b1;
        held = result;
        a = 8'd5; b = 8'd6; start = 1'b1;
        n = 0; found = 1'b0; rv_seen = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (dp_s && dp_op == 2'b01) found = 1'b1;
        end
        chk("loada_seen", 32'(found), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (result_valid) rv_seen = 1'b1;
        end
        chk("err_not_early", 32'(err), 32'd0);
        chk("busy_in_wait", 32'(busy), 32'd1);
        @(negedge clk);
        chk("err_at_timeout", 32'(err), 32'd1);
        chk("busy_in_err", 32'(busy), 32'd0);
        chk("err_result_kept", 32'(result), 32'(held));
        chk("err_dp_op", 32'(dp_op), 32'd0);
        chk("err_no_valid", 32'(rv_seen), 32'd0);
        arm_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        run_op(8'd2, 8'd4, 0, 34, 11);
        chk("err_cleared", 32'(err), 32'd0);

        // Second request during STEP commands must be ignored.
        run_op(8'd6, 8'd7, 15, 34, 11);

        // Reset in the middle of LOADB.
        a = 8'd4; b = 8'd4; start = 1'b1;
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (dp_s && dp_op == 2'b10) found = 1'b1;
        end
        chk("loadb_seen", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_dp_s", 32'(dp_s), 32'd0);
        chk("async_dp_op", 32'(dp_op), 32'd0);
        chk("async_dp_in", 32'(dp_in), 32'd0);
        chk("async_result", 32'(result), 32'd0);
        start = 1'b1; a = 8'd1; b = 8'd1;
        repeat (2) @(negedge clk);
        chk("reset_beats_start", 32'(busy), 32'd0);
        reset = 1'b0; start = 1'b0;
        n = 0; rv_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dp_s) n++;
            if (result_valid) rv_seen = 1'b1;
        end
        chk("no_cmd_without_start", n, 0);
        chk("no_valid_after_reset", 32'(rv_seen), 32'd0);
        run_op(8'd7, 8'd6, 0, 34, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
